// File: rtl/fifo_sync_paced_if.sv
// Handshake and status bundle for fifo_sync_paced. The master side is the producer/consumer
// environment; the slave side is the FIFO itself.
interface fifo_sync_paced_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PTR_WIDTH     = 8,
  parameter int unsigned DIV_WIDTH     = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
);
  logic                     w_en;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     r_en;
  logic [DIV_WIDTH-1:0]     wr_div;
  logic [DIV_WIDTH-1:0]     rd_div;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     w_ready;
  logic                     r_ready;
  logic                     full;
  logic                     empty;
  logic                     half_full;
  logic                     almost_full;
  logic                     almost_empty;
  logic [PTR_WIDTH:0]       count;
  logic                     write_error;
  logic                     read_error;
  logic [ERR_CNT_WIDTH-1:0] wr_err_cnt;
  logic [ERR_CNT_WIDTH-1:0] rd_err_cnt;

  modport master (
    output w_en, data_in, r_en, wr_div, rd_div,
    input  data_out, data_valid, w_ready, r_ready, full, empty, half_full, almost_full,
           almost_empty, count, write_error, read_error, wr_err_cnt, rd_err_cnt
  );

  modport slave (
    input  w_en, data_in, r_en, wr_div, rd_div,
    output data_out, data_valid, w_ready, r_ready, full, empty, half_full, almost_full,
           almost_empty, count, write_error, read_error, wr_err_cnt, rd_err_cnt
  );
endinterface

// File: rtl/fifo_sync_paced.sv
// Single-clock FIFO with independent write/read rate pacing, occupancy flags and
// saturating error counters. wrst_n is a synchronous, active-high reset.
module fifo_sync_paced #(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PTR_WIDTH     = 8,
  parameter int unsigned DIV_WIDTH     = 4,
  parameter int unsigned AF_THRESH     = DEPTH - 4,
  parameter int unsigned AE_THRESH     = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_sync_paced_if.slave  bus
);

  localparam int unsigned CntW = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_WIDTH:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DIV_WIDTH-1:0]     wr_pc_q, wr_pc_d, rd_pc_q, rd_pc_d;
  logic [DIV_WIDTH-1:0]     wr_eff, rd_eff;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     write_error_q, write_error_d;
  logic                     read_error_q, read_error_d;
  logic [ERR_CNT_WIDTH-1:0] wr_err_cnt_q, wr_err_cnt_d, rd_err_cnt_q, rd_err_cnt_d;
  logic                     wr_slot, rd_slot, full, empty, wr_acc, rd_acc;
  logic [PTR_WIDTH:0]       count;

  always_comb begin
    wr_eff  = (bus.wr_div == '0) ? DIV_WIDTH'(1) : bus.wr_div;
    rd_eff  = (bus.rd_div == '0) ? DIV_WIDTH'(1) : bus.rd_div;
    wr_slot = (wr_pc_q == '0);
    rd_slot = (rd_pc_q == '0);
    // >= rather than == so a divider lowered below pc+1 wraps on the next edge
    wr_pc_d = (wr_pc_q >= wr_eff - DIV_WIDTH'(1)) ? '0 : wr_pc_q + DIV_WIDTH'(1);
    rd_pc_d = (rd_pc_q >= rd_eff - DIV_WIDTH'(1)) ? '0 : rd_pc_q + DIV_WIDTH'(1);

    full   = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
             (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
    empty  = (wptr_q == rptr_q);
    count  = wptr_q - rptr_q;
    // Gating uses current-cycle flags only: no pass-through at full, no bypass at empty
    wr_acc = bus.w_en && wr_slot && !full;
    rd_acc = bus.r_en && rd_slot && !empty;

    wptr_d        = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d        = rd_acc ? rptr_q + 1'b1 : rptr_q;
    data_out_d    = rd_acc ? mem_q[rptr_q[PTR_WIDTH-1:0]] : data_out_q;
    data_valid_d  = rd_acc;
    write_error_d = bus.w_en && full;
    read_error_d  = bus.r_en && empty;
    wr_err_cnt_d  = (write_error_d && (wr_err_cnt_q != '1)) ? wr_err_cnt_q + 1'b1
                                                              : wr_err_cnt_q;
    rd_err_cnt_d  = (read_error_d && (rd_err_cnt_q != '1)) ? rd_err_cnt_q + 1'b1
                                                             : rd_err_cnt_q;
  end

  always_ff @(posedge wclk) begin
    if (wrst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      wr_pc_q       <= '0;
      rd_pc_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      write_error_q <= 1'b0;
      read_error_q  <= 1'b0;
      wr_err_cnt_q  <= '0;
      rd_err_cnt_q  <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      wr_pc_q       <= wr_pc_d;
      rd_pc_q       <= rd_pc_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      write_error_q <= write_error_d;
      read_error_q  <= read_error_d;
      wr_err_cnt_q  <= wr_err_cnt_d;
      rd_err_cnt_q  <= rd_err_cnt_d;
    end
  end

  // Storage is never cleared; only gated so reset wins over a same-cycle write
  always_ff @(posedge wclk) begin
    if (!wrst_n && wr_acc) begin
      mem_q[wptr_q[PTR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.w_ready      = wr_slot && !full;
  assign bus.r_ready      = rd_slot && !empty;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.half_full    = (count >= CntW'(DEPTH / 2));
  assign bus.almost_full  = (count >= CntW'(AF_THRESH));
  assign bus.almost_empty = (count <= CntW'(AE_THRESH));
  assign bus.count        = count;
  assign bus.write_error  = write_error_q;
  assign bus.read_error   = read_error_q;
  assign bus.wr_err_cnt   = wr_err_cnt_q;
  assign bus.rd_err_cnt   = rd_err_cnt_q;

endmodule

// File: doc/fifo_sync_paced.md
Name: fifo_sync_paced

Overview:
- Single-clock, parametrised FIFO buffer with rate pacing on both the write and read sides.
- Write and read acceptance are each gated by a runtime-programmable divider: only every Nth cycle is an active slot.
- Adds occupancy count, half, almost-full and almost-empty flags, per-access error pulses, and saturating error counters.
- Sits between a bursty producer and a rate-limited consumer inside one clock domain.

Parameters:
- DEPTH, 256, number of entries; must equal 2**PTR_WIDTH.
- DATA_WIDTH, 8, data word width.
- PTR_WIDTH, 8, address width; pointers are PTR_WIDTH+1 bits (extra wrap bit).
- DIV_WIDTH, 4, width of the runtime divider inputs.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.
- ERR_CNT_WIDTH, 8, width of the saturating error counters.

Ports:
- wclk  in  1  sole clock; all logic on its rising edge.
- wrst_n  in  1  reset: synchronous, active-high (1 = reset) despite the suffix.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request.
- wr_div  in  DIV_WIDTH  write pacing divider; 0 is treated as 1.
- rd_div  in  DIV_WIDTH  read pacing divider; 0 is treated as 1.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- w_ready  out  1  comb: write slot active and !full.
- r_ready  out  1  comb: read slot active and !empty.
- full, empty  out  1  occupancy flags.
- half_full  out  1  count >= DEPTH/2.
- almost_full, almost_empty  out  1  threshold flags.
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- write_error, read_error  out  1  registered one-cycle error pulses.
- wr_err_cnt, rd_err_cnt  out  ERR_CNT_WIDTH  saturating error totals.

Behaviour:
- Reset (wrst_n=1 at an edge):
  - Pointers, count, pacing counters, data_out, data_valid, errors and error counters all go to 0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0, half_full=0.
  - Memory contents are not cleared.
  - Reset overrides any same-cycle access, including mid-burst.
- Pacing:
  - Each side has a counter pc and an effective divider eff = (div==0) ? 1 : div.
  - The side has a slot when pc==0.
  - pc advances each cycle and wraps to 0 when pc >= eff-1.
  - The first cycle after reset is a slot.
  - If div is lowered below pc+1, pc wraps to 0 on the next edge.
- Write:
  - Accepted when w_en && slot && !full: mem[wptr[PTR_WIDTH-1:0]] <= data_in, then wptr++.
  - w_en && full (slot or not): write_error pulses the next cycle and wr_err_cnt increments.
  - w_en on a non-slot cycle while not full is silently ignored, with no error.
- Read:
  - Accepted when r_en && slot && !empty: data_out <= mem[rptr], data_valid=1 the next cycle, then rptr++.
  - Read latency is 1 cycle. data_out holds its value between reads.
  - r_en && empty: read_error pulses and rd_err_cnt increments. data_out is unchanged.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full/empty gating:
  - At full, a write is rejected even if a read is accepted in the same cycle (no pass-through).
  - At empty, a read is rejected even if a write is accepted in the same cycle (no bypass).
- Flags:
  - full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) && equal low bits.
  - empty = (wptr == rptr).
  - count = wptr - rptr, modulo 2**(PTR_WIDTH+1).
  - All flags derive from registered pointers and are therefore registered-equivalent.
- Pointers wrap naturally at 2**(PTR_WIDTH+1).
- Error counters saturate at all-ones and stay there until reset.

Test Plan:
- Reset, then wr_div=1, rd_div=1; write 0x01..0x05 on consecutive cycles, then read 5 times -> data_out 0x01..0x05, each 1 cycle after its read; count returns to 0; empty=1.
- wr_div=2, w_en held high for 8 cycles with data 0xA0+i -> only the 4 slot-cycle words (0xA0, 0xA2, 0xA4, 0xA6) stored; count=4; no write_error.
- Fill to DEPTH=256 -> full=1, almost_full=1, count=256. Then one extra w_en -> write_error pulse, wr_err_cnt=1, stored data intact.
- From full, assert w_en and r_en together on a slot -> read accepted, write rejected with write_error, count=255. Repeat the read on empty -> read_error, rd_err_cnt=1, data_out unchanged.
- Push 300 words through, interleaving reads -> pointers wrap, order preserved.
- Force 300 reads on empty -> rd_err_cnt saturates at 255.
- Assert wrst_n mid-burst with count=10 -> next cycle count=0, empty=1, error counters 0, w_ready=1 (slot).
